// File: rtl/sc_mul_stream_if.sv
// Operand/result handshake bundle for the stochastic-computing multiplier.
// The slave modport is the multiplier's view; the master side drives operands and consumes results.
interface sc_mul_stream_if #(
  parameter int IN_WIDTH  = 6,
  parameter int OUT_WIDTH = 6
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  a_in;
  logic [IN_WIDTH-1:0]  b_in;
  logic                 mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] sc_result;
  logic                 busy;

  modport master (
    output in_valid, a_in, b_in, mode, out_ready,
    input  in_ready, out_valid, sc_result, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, mode, out_ready,
    output in_ready, out_valid, sc_result, busy
  );
endinterface

// File: rtl/sc_mul_stream.sv
// Multi-cycle stochastic-computing multiplier: LANES stream bits per cycle from
// van der Corput (A) and ramp (B) sequences, combined by AND/XNOR and popcounted.
module sc_mul_stream #(
  parameter int LOG_LEN   = 5,
  parameter int LANES     = 8,
  parameter int IN_WIDTH  = LOG_LEN + 1,
  parameter int OUT_WIDTH = LOG_LEN + 1
) (
  input  logic               clk,
  input  logic               rst,
  sc_mul_stream_if.slave     bus
);

  localparam int L     = 1 << LOG_LEN;
  localparam int N     = L / LANES;
  localparam int CW    = LOG_LEN + 1;
  localparam int K_W   = (N > 1) ? $clog2(N) : 1;
  localparam int SAT_W = (IN_WIDTH > CW) ? IN_WIDTH : CW;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      a_q, b_q;
  logic               mode_q;
  logic [K_W-1:0]     k_q;
  logic [CW-1:0]      acc_q;
  logic [CW-1:0]      result_q;

  logic               in_ready;
  logic               accept;
  logic               k_last;
  logic [CW-1:0]      lane_cnt;
  logic [CW-1:0]      acc_sum;
  logic [LOG_LEN-1:0] idx;
  logic [LOG_LEN-1:0] rev;
  logic               sa, sb, bit_v;

  // Operands above L carry no extra probability mass; clamp them to L.
  function automatic logic [CW-1:0] saturate(input logic [IN_WIDTH-1:0] v);
    logic [SAT_W-1:0] wide;
    wide = SAT_W'(v);
    if (wide > SAT_W'(L)) return CW'(L);
    else                  return CW'(wide);
  endfunction

  assign k_last = (k_q == K_W'(N - 1));

  // NOTE: blocking '=' is correct inside always_comb; the popcount relies on
  // each loop iteration seeing the previous iteration's running total.
  always_comb begin
    lane_cnt = '0;
    idx      = '0;
    rev      = '0;
    sa       = 1'b0;
    sb       = 1'b0;
    bit_v    = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      idx = LOG_LEN'(int'(k_q) * LANES + j);
      for (int b = 0; b < LOG_LEN; b++) rev[b] = idx[LOG_LEN-1-b];
      sa    = ({1'b0, rev} < a_q);
      sb    = ({1'b0, idx} < b_q);
      bit_v = mode_q ? ~(sa ^ sb) : (sa & sb);
      lane_cnt = lane_cnt + CW'(bit_v);
    end
  end

  assign acc_sum = acc_q + lane_cnt;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    in_ready = !rst && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
    accept   = bus.in_valid && in_ready;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (k_last) state_d = DONE;
      DONE: begin
        // A result handshake coinciding with a new accept skips IDLE entirely.
        if (accept)             state_d = RUN;
        else if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      k_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q    <= saturate(bus.a_in);
        b_q    <= saturate(bus.b_in);
        mode_q <= bus.mode;
        k_q    <= '0;
        acc_q  <= '0;
      end else if (state_q == RUN) begin
        k_q   <= k_q + K_W'(1);
        acc_q <= acc_sum;
        if (k_last) result_q <= acc_sum;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.sc_result = OUT_WIDTH'(result_q);
  assign bus.busy      = (state_q != IDLE);

endmodule
